// File: rtl/clk_div_gen.sv
// clk_div_gen -- programmable divider / timebase generator on a single clock.
//
// Produces a one-cycle clock-enable `tick` every D cycles of `clk`, a 50 %
// square wave `fout` in toggle mode, and a single delayed tick in one-shot
// mode. No generated signal is meant to be used as a clock.
//
// Ports:
//   clk      in   system clock, all updates on posedge
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable, low pauses the block
//   mode     in   00 periodic, 01 toggle, 10 one-shot, 11 behaves as 00
//   div      in   new divisor (period in clk cycles, 0 behaves as 1)
//   div_load in   one-cycle strobe capturing div
//   start    in   one-shot trigger, only honoured in mode 10
//   tick     out  registered one-cycle pulse at each period end
//   fout     out  registered square output (mode 01), 0 otherwise
//   busy     out  registered, high while a one-shot is counting
//   cnt      out  current counter value
module clk_div_gen #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] div,
  input  logic             div_load,
  input  logic             start,
  output logic             tick,
  output logic             fout,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    MODE_TICK    = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  // A zero divisor saturates to one so the wrap threshold never underflows.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_v_q, pend_v_d;
  mode_e            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             fout_q, fout_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] last_cnt;
  logic             wrap;
  logic             oneshot;
  logic             idle;

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_v_d   = pend_v_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    fout_d     = fout_q;
    busy_d     = busy_q;

    last_cnt = eff_div(div_act_q) - WIDTH'(1);
    // >= rather than == lets an out-of-range count recover on its own.
    wrap     = (cnt_q >= last_cnt);
    oneshot  = (mode_q == MODE_ONESHOT);
    idle     = !en || (oneshot && !busy_q);

    if (mode_e'(mode) != mode_q) begin
      // Mode switch restarts the timebase; a pending divisor survives it.
      mode_d = mode_e'(mode);
      cnt_d  = '0;
      fout_d = 1'b0;
      busy_d = 1'b0;
      if (div_load) begin
        div_pend_d = div;
        pend_v_d   = 1'b1;
      end
    end else if (idle) begin
      if (oneshot && en && start) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end
      if (div_load) begin
        div_act_d = div;
        cnt_d     = '0;
        pend_v_d  = 1'b0;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode_q == MODE_TOGGLE) fout_d = !fout_q;
      if (oneshot)               busy_d = 1'b0;
      // A load landing on the wrap edge beats the older shadow value.
      if (div_load) begin
        div_act_d = div;
        pend_v_d  = 1'b0;
      end else if (pend_v_q) begin
        div_act_d = div_pend_q;
        pend_v_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (div_load) begin
        div_pend_d = div;
        pend_v_d   = 1'b1;
      end
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= RST_DIV;
      pend_v_q  <= 1'b0;
      mode_q    <= MODE_TICK;
      tick_q    <= 1'b0;
      fout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      pend_v_q  <= pend_v_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      fout_q    <= fout_d;
      busy_q    <= busy_d;
    end
  end

  // Shadow value is only consumed when pend_v_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    div_pend_q <= div_pend_d;
  end

  assign tick = tick_q;
  assign fout = fout_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule
